// File: rtl/cdb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdb_arb_pkg : shared CDB packet type and sizing constants                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cdb_arb_pkg;

  localparam int PRW       = 6;
  localparam int TRW       = 5;
  localparam int CDB_LANES = 4;
  localparam int CDB_SRCS  = 6;

  typedef struct packed {
    logic           en;
    logic [PRW-1:0] tag;
    logic           t_en;
    logic [TRW-1:0] t_tag;
  } Cdb_pkt_t;

  // A packet with neither field enabled carries nothing worth broadcasting.
  function automatic logic pkt_live(input Cdb_pkt_t p);
    return p.en | p.t_en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdb_src_fifo : per-source circular FIFO of CDB packets                     |
// | Revision     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module cdb_src_fifo
  import cdb_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  Cdb_pkt_t      i_push_pkt,
  input  logic          i_pop,
  input  logic          i_flush,
  output Cdb_pkt_t      o_head,
  output logic          o_head_valid,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  Cdb_pkt_t      r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= ptr_inc(r_wr);
      if (i_pop)  r_rd <= ptr_inc(r_rd);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !(rst || i_flush)) r_mem[r_wr] <= i_push_pkt;
  end

  assign o_head       = r_mem[r_rd];
  assign o_head_valid = (r_count != '0);
  assign o_count      = r_count;

endmodule
`default_nettype wire

// File: rtl/cdb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdb_arb : round-robin common data bus arbiter with per-source FIFOs        |
// | Option  : define CDB_BYPASS_EN for same-cycle bypass of empty FIFOs        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module cdb_arb
  import cdb_arb_pkg::*;
#(
  parameter int NSRC  = CDB_SRCS,
  parameter int DEPTH = 2,
  parameter int NLANE = CDB_LANES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_recovery_en,
  input  logic     [NSRC-1:0]   i_wb_valid,
  input  Cdb_pkt_t [NSRC-1:0]   i_wb_pkt,
  output logic     [NSRC-1:0]   o_wb_rdy,
  output Cdb_pkt_t [NLANE-1:0]  o_cdb_pkt,
  output logic                  o_cdb_busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int LW = (NLANE > 1) ? $clog2(NLANE) : 1;

  logic     [NSRC-1:0]         w_accept, w_live, w_byp, w_cand, w_grant;
  logic     [NSRC-1:0]         w_push, w_pop, w_head_valid, w_nonempty_nxt;
  Cdb_pkt_t [NSRC-1:0]         w_head, w_cand_pkt;
  logic     [NSRC-1:0][CW-1:0] w_count;
  Cdb_pkt_t [NLANE-1:0]        w_lane;
  logic     [RW-1:0]           w_rr_nxt;
  logic     [RW-1:0]           r_rr;
  Cdb_pkt_t [NLANE-1:0]        r_cdb_pkt;
  logic                        r_cdb_busy;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign o_wb_rdy[i] = (w_count[i] < CW'(DEPTH));
    assign w_accept[i] = i_wb_valid[i] & o_wb_rdy[i];
    assign w_live[i]   = w_accept[i] & pkt_live(i_wb_pkt[i]);
`ifdef CDB_BYPASS_EN
    assign w_byp[i]    = w_live[i] & ~w_head_valid[i];
`else
    assign w_byp[i]    = 1'b0;
`endif
    assign w_cand[i]     = w_head_valid[i] | w_byp[i];
    assign w_cand_pkt[i] = w_head_valid[i] ? w_head[i] : i_wb_pkt[i];
    assign w_pop[i]      = w_grant[i] & w_head_valid[i];
    // A bypassed packet that wins a lane never lands in the FIFO.
    assign w_push[i]     = w_live[i] & ~(w_grant[i] & w_byp[i]);
    assign w_nonempty_nxt[i] =
        (w_count[i] + CW'(w_push[i]) - CW'(w_pop[i])) != '0;

    cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push[i]),
      .i_push_pkt   (i_wb_pkt[i]),
      .i_pop        (w_pop[i]),
      .i_flush      (i_recovery_en),
      .o_head       (w_head[i]),
      .o_head_valid (w_head_valid[i]),
      .o_count      (w_count[i])
    );
  end

  always_comb begin
    int            w_used;
    int            w_sum;
    logic [RW-1:0] w_idx;
    logic [LW-1:0] w_slot;
    w_grant  = '0;
    w_lane   = '0;
    w_rr_nxt = r_rr;
    w_used   = 0;
    w_sum    = 0;
    w_idx    = '0;
    w_slot   = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_sum = int'(r_rr) + k;
      if (w_sum >= NSRC) w_sum = w_sum - NSRC;
      w_idx = RW'(w_sum);
      if (w_cand[w_idx] && (w_used < NLANE)) begin
        w_slot          = LW'(w_used);
        w_grant[w_idx]  = 1'b1;
        w_lane[w_slot]  = w_cand_pkt[w_idx];
        w_rr_nxt        = (w_sum == NSRC - 1) ? '0 : RW'(w_sum + 1);
        w_used          = w_used + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr       <= '0;
      r_cdb_pkt  <= '0;
      r_cdb_busy <= 1'b0;
    end else if (i_recovery_en) begin
      r_cdb_pkt  <= '0;
      r_cdb_busy <= 1'b0;
    end else begin
      r_rr       <= w_rr_nxt;
      r_cdb_pkt  <= w_lane;
      r_cdb_busy <= |w_nonempty_nxt;
    end
  end

  assign o_cdb_pkt  = r_cdb_pkt;
  assign o_cdb_busy = r_cdb_busy;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cdb_arb : directed vector bench for cdb_arb (honours CDB_BYPASS_EN)     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cdb_arb;
  import cdb_arb_pkg::*;

`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            rec;
  logic     [5:0]  vld;
  Cdb_pkt_t [5:0]  pkt;
  logic     [5:0]  rdy;
  Cdb_pkt_t [3:0]  cdb;
  logic            busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdb_arb #(.NSRC(6), .DEPTH(2), .NLANE(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_recovery_en (rec),
    .i_wb_valid    (vld),
    .i_wb_pkt      (pkt),
    .o_wb_rdy      (rdy),
    .o_cdb_pkt     (cdb),
    .o_cdb_busy    (busy)
  );

  typedef struct packed {
    logic            rst;
    logic [5:0]      vld;
    logic [5:0]      base;
    logic [3:0]      en;
    logic [3:0][5:0] tag;
    logic            busy;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic Cdb_pkt_t mk(input logic en, input logic [5:0] tag,
                                  input logic ten, input logic [4:0] ttag);
    Cdb_pkt_t p;
    p.en = en; p.tag = tag; p.t_en = ten; p.t_tag = ttag;
    return p;
  endfunction

  task automatic add(input logic r, input logic [5:0] v, input logic [5:0] b,
                     input logic [3:0] e, input logic [5:0] t0, input logic [5:0] t1,
                     input logic [5:0] t2, input logic [5:0] t3, input logic bz);
    vec_t x;
    x.rst = r; x.vld = v; x.base = b; x.en = e;
    x.tag[0] = t0; x.tag[1] = t1; x.tag[2] = t2; x.tag[3] = t3;
    x.busy = bz;
    tbl.push_back(x);
  endtask

  int seq_tx[6], seq_rx[6], pend[6], pb[6], waitc[6];
  logic [5:0] got_src;

  initial begin
    Cdb_pkt_t       e;
    Cdb_pkt_t [3:0] got, exp_l;
    logic [5:0]     w;
    int got_at, nz, hits, acc, bc, rdy_low, order_err, dup_err, maxwait, src;

    rst = 1'b1; rec = 1'b0; vld = '0; pkt = '0;
    tick(); tick();
    chk("reset cdb_pkt", cdb, '0);
    chk("reset busy", busy, 0);
    chk("reset wb_rdy", rdy, 6'h3f);

    // Oversubscription, rr wrap and the single-packet case, from rr=0.
    add(1, 6'h00, 6'h00, 4'h0, 0, 0, 0, 0, 0);
    add(0, 6'h3f, 6'h20, BYP ? 4'hf : 4'h0, 6'h20, 6'h21, 6'h22, 6'h23, 1);
    if (!BYP) add(0, 6'h00, 6'h00, 4'hf, 6'h20, 6'h21, 6'h22, 6'h23, 1);
    add(0, 6'h00, 6'h00, 4'h3, 6'h24, 6'h25, 0, 0, 0);
    add(0, 6'h00, 6'h00, 4'h0, 0, 0, 0, 0, 0);
    add(0, 6'h31, 6'h30, BYP ? 4'h7 : 4'h0, 6'h30, 6'h34, 6'h35, 0, !BYP);
    if (!BYP) add(0, 6'h00, 6'h00, 4'h7, 6'h30, 6'h34, 6'h35, 0, 0);
    add(0, 6'h04, 6'h13, BYP ? 4'h1 : 4'h0, 6'h15, 0, 0, 0, !BYP);
    if (!BYP) add(0, 6'h00, 6'h00, 4'h1, 6'h15, 0, 0, 0, 0);
    add(0, 6'h0a, 6'h10, BYP ? 4'h3 : 4'h0, 6'h13, 6'h11, 0, 0, !BYP);
    if (!BYP) add(0, 6'h00, 6'h00, 4'h3, 6'h13, 6'h11, 0, 0, 0);
    add(0, 6'h00, 6'h00, 4'h0, 0, 0, 0, 0, 0);

    for (int j = 0; j < tbl.size(); j++) begin
      rst = tbl[j].rst;
      vld = tbl[j].vld;
      for (int i = 0; i < 6; i++) pkt[i] = mk(1'b1, tbl[j].base + 6'(i), 1'b0, 5'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
        e = '0;
        if (tbl[j].en[k]) e = mk(1'b1, tbl[j].tag[k], 1'b0, 5'd0);
        chk($sformatf("vec%0d lane%0d", j, k), cdb[k], e);
      end
      chk($sformatf("vec%0d busy", j), busy, tbl[j].busy);
      chk($sformatf("vec%0d wb_rdy", j), rdy, 6'h3f);
    end
    rst = 1'b0; vld = '0; pkt = '0;

    // Null packet then t-only packet from source 1.
    pkt[1] = mk(1'b0, 6'd0, 1'b0, 5'd0);
    vld = 6'b000010;
    tick();
    chk("null lanes", cdb, '0);
    chk("null busy", busy, 0);
    pkt[1] = mk(1'b0, 6'd0, 1'b1, 5'd3);
    got_at = 0; nz = 0; got = '0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vld = '0;
      if (cdb != '0) begin
        nz++;
        if (got_at == 0) begin got_at = c; got = cdb; end
      end
    end
    exp_l = '0;
    exp_l[0] = mk(1'b0, 6'd0, 1'b1, 5'd3);
    chk("tonly latency", got_at, LAT);
    chk("tonly lanes", got, exp_l);
    chk("tonly broadcast count", nz, 1);

    // Recovery: load the FIFOs, then flush together with a source-0 offer of 0x3F.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 6; i++) pkt[i] = mk(1'b1, 6'(i), 1'b0, 5'd0);
      vld = 6'h3f & rdy;
      tick();
    end
    chk("pre-recovery busy", busy, 1);
    rec = 1'b1;
    vld = 6'b000001;
    pkt[0] = mk(1'b1, 6'h3f, 1'b0, 5'd0);
    tick();
    rec = 1'b0; vld = '0;
    chk("recovery lanes", cdb, '0);
    chk("recovery busy", busy, 0);
    chk("recovery wb_rdy", rdy, 6'h3f);
    hits = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int k = 0; k < 4; k++) if (cdb[k].en && cdb[k].tag == 6'h3f) hits++;
      if (cdb != '0 || busy) hits++;
    end
    chk("post-recovery quiet", hits, 0);

    // Back-pressure stream: all sources, 60 cycles, then drain.
    for (int i = 0; i < 6; i++) begin seq_tx[i] = 0; seq_rx[i] = 0; pend[i] = 0; waitc[i] = 0; end
    acc = 0; bc = 0; rdy_low = 0; order_err = 0; dup_err = 0; maxwait = 0;
    for (int c = 0; c < 72; c++) begin
      for (int i = 0; i < 6; i++) pkt[i] = mk(1'b1, {3'(i), 3'(seq_tx[i])}, 1'b0, 5'd0);
      vld = (c < 60) ? 6'h3f : 6'h00;
      w = vld & rdy;
      if (c < 60 && rdy != 6'h3f) rdy_low++;
      tick();
      got_src = '0;
      for (int i = 0; i < 6; i++) begin
        pb[i] = pend[i];
        if (w[i]) begin seq_tx[i]++; pend[i]++; acc++; end
      end
      for (int k = 0; k < 4; k++) begin
        if (cdb[k].en) begin
          src = int'(cdb[k].tag[5:3]);
          if (src > 5) order_err++;
          else begin
            if (cdb[k].tag[2:0] != 3'(seq_rx[src])) order_err++;
            if (got_src[src]) dup_err++;
            got_src[src] = 1'b1;
            seq_rx[src]++;
            pend[src]--;
          end
          bc++;
        end
      end
      for (int i = 0; i < 6; i++) begin
        if (pb[i] > 0 && !got_src[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > maxwait) maxwait = waitc[i];
      end
    end
    chk("stream accepted==broadcast", bc, acc);
    chk("stream accepted some", acc > 60, 1);
    chk("stream order", order_err, 0);
    chk("stream one per source", dup_err, 0);
    chk("stream wb_rdy dropped", rdy_low != 0, 1);
    chk("stream starvation<=2", maxwait <= 2, 1);
    chk("stream drained busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arb.md
# cdb_arb

Common data bus arbiter and broadcaster. It collects completion packets from up to `NSRC` functional-unit writeback ports, buffers each port in a small FIFO, and drives up to 4 `Cdb_pkt_t` lanes per cycle. Reservation stations, the busy-bit tables and the ROB consume those lanes. Source selection is round-robin, and each source receives back-pressure through `wb_rdy`, which feeds the FU's `fu_rdy` logic.

## Interface
- `NSRC`, default 6: number of writeback sources.
- `DEPTH`, default 2: per-source FIFO entries; must be ≥1.
- `NLANE`, default 4: CDB lanes; must equal the consumer `cdb_pkt` width.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `recovery_en`  in  1  misprediction flush; acts as a synchronous clear, like `rst`.
- `wb_valid`  in  NSRC  source i offers `wb_pkt[i]`.
- `wb_pkt`  in  NSRC×`Cdb_pkt_t`  completion packet with fields `en`, `tag[PRW]`, `t_en`, `t_tag[TRW]`.
- `wb_rdy`  out  NSRC  source i FIFO can accept.
- `cdb_pkt`  out  NLANE×`Cdb_pkt_t`  broadcast lanes; registered.
- `cdb_busy`  out  1  any source FIFO non-empty; registered.

## Operation
- **Accept.** Source i transfers on a clock edge where `wb_valid[i] && wb_rdy[i]`. The producer holds `wb_pkt[i]` stable until it is accepted.
- **Ready.** `wb_rdy[i] = count[i] < DEPTH`, computed from the registered count only. A FIFO that is full does not accept in the same cycle it pops; there is no full pass-through.
- **Null packets.** A packet with `en=0 && t_en=0` is accepted and then discarded. It never occupies a FIFO slot or a lane.
- **Candidates.** Each cycle, every source whose FIFO head is valid is a candidate. At most one packet per source is granted per cycle.
- **Arbitration.** Scan candidates starting at round-robin pointer `rr` in the order `rr, rr+1, … mod NSRC`. Grant the first `NLANE` candidates. The k-th grant is placed on lane k. Unused lanes have `en=0`, `t_en=0`, and zero tags.
- **Pointer update.**
  - If any grant was made, `rr` moves to one past the last granted source, mod `NSRC`.
  - If there were no grants, `rr` is unchanged.
- **Pop.** A granted source pops its head at the same edge that loads `cdb_pkt`.
- **Ordering.** Per-source FIFO order is preserved. There is no ordering guarantee across sources.
- **Fields.** `en/tag` and `t_en/t_tag` are forwarded unmodified. A packet with only `t_en=1` still uses a whole lane.
- **Recovery.** With `recovery_en=1` at an edge:
  - all FIFOs are emptied;
  - `cdb_pkt` is cleared to zero and `cdb_busy` to 0;
  - any acceptance in that cycle is discarded;
  - `rr` is kept.
- **Reset.** With `rst=1` at an edge, the recovery actions apply, and additionally `rr=0`.
- **Reset values.**
  - `cdb_pkt` is all zero.
  - `cdb_busy=0`.
  - `wb_rdy` is all ones from the first cycle after reset.
- **Precedence.** `rst` > `recovery_en` > normal operation.

## Timing
- Without bypass, `wb_valid` accepted at edge E0 is written to the FIFO at E0. It can be arbitrated in the following cycle and appears on `cdb_pkt` after E1. Minimum latency is 2 edges.
- Each lane packet is valid for exactly one cycle. Consumers sample it at the next edge.
- Sustained throughput is `min(NLANE, active sources)` packets per cycle, with at most 1 per source per cycle.
- Bypass behaviour is set under Configuration.

## Configuration
- `CDB_BYPASS_EN` defined:
  - A source whose FIFO is empty, offering an accepted packet with `en|t_en` set, is a candidate in the same cycle.
  - If granted, the packet appears on `cdb_pkt` after E0 (latency 1) and is not written to the FIFO.
  - If not granted, it is enqueued normally.
- `CDB_BYPASS_EN` undefined: all packets go through the FIFO, with latency 2.
- `wb_rdy` semantics are identical in both builds.

## Structure
- The shared package holds:
  - `Cdb_pkt_t`, `PRW`, `TRW` (already shared with the RS);
  - `CDB_LANES=4`;
  - `CDB_SRCS` (the default `NSRC`).
- Sub-module `cdb_src_fifo`: parameterized by `DEPTH`; holds `Cdb_pkt_t` entries; ports are push, pop, flush, head, head_valid and count. It is instantiated `NSRC` times.
- The arbiter, the pointer and the output register live in `cdb_arb`.

## Test plan
1. **Reset.** Hold `rst` for 2 cycles, then release → `cdb_pkt` is all zero, `cdb_busy=0`, `wb_rdy=6'b111111`, `rr=0`.
2. **Single packet.** Source 2 sends `{en=1, tag=0x15, t_en=0}` at cycle 0 → lane 0 carries `tag 0x15` in cycle 2 only (cycle 1 with `CDB_BYPASS_EN`); lanes 1–3 have `en=0`.
3. **Oversubscription.** All 6 sources send one packet in the same cycle with `rr=0` → first broadcast cycle: sources 0,1,2,3 on lanes 0–3, `rr=4`. Next cycle: sources 4,5 on lanes 0,1, `rr=0`. Then `cdb_busy=0`.
4. **Back-pressure.** All 6 sources stream tags continuously for 60 cycles →
   - `wb_rdy` drops intermittently;
   - broadcasts total exactly the number accepted;
   - every source's tags arrive in issue order;
   - no source starves for more than 2 cycles.
5. **Recovery.** Fill every FIFO, then pulse `recovery_en` together with `wb_valid[0]` carrying `tag 0x3F` → the next cycle has all lanes zero, `cdb_busy=0`, `wb_rdy` all ones, and `tag 0x3F` never appears.
6. **Null and t-only packets.** Source 1 sends `{en=0, t_en=0}`, then `{en=0, t_en=1, t_tag=3}` → the first is never broadcast and uses no lane; the second appears on lane 0 with `t_en=1`, `t_tag=3`, `en=0`.
